// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access controller.
// Holds the FSM encoding, the user-mode address window and the timeout default.
package lc3_mem_pkg;

   // One-hot so each status output decodes from a single flop
   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      ACCESS = 3'b010,
      DONE   = 3'b100
   } state_t;

   localparam logic [15:0] USER_LO     = 16'h3000;
   localparam logic [15:0] USER_HI     = 16'hFE00;
   localparam int          TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus LC-3 Mem bus, bundled in one interface.
// master = the access controller, slave = control FSM and memory side.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              priv;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_acv;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] inData;
   logic              MIOEN;
   logic              RW;
   logic [DATA_W-1:0] outData;
   logic              R;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, priv,
      input  outData, R,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_acv,
      output addr, inData, MIOEN, RW
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, priv,
      output outData, R,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_acv,
      input  addr, inData, MIOEN, RW
   );
endinterface

// File: rtl/lc3_acv_check.sv
// User-mode access-violation check: user code may only touch x3000..xFDFF.
// Purely combinational; instantiated by the controller only with MEM_ACV_EN.
module lc3_acv_check
   import lc3_mem_pkg::*;
#(
   parameter int ADDR_W = 16
)(
   input  logic [ADDR_W-1:0] addr,
   input  logic              priv,
   output logic              viol
);
   assign viol = priv &&
                 ((addr <  ADDR_W'(USER_LO)) ||
                  (addr >= ADDR_W'(USER_HI)));
endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 CPU-side memory initiator: holds MAR/MDR, drives Mem until R or timeout.
// Optional user-mode access-violation check enabled by `define MEM_ACV_EN.
module mem_access_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 16
)(
   input logic               clk,
   input logic               rst,
   mem_access_ctrl_if.master bus
);
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t            state;
   state_t            nxt;
   logic [ADDR_W-1:0] mar;
   logic [DATA_W-1:0] mdr;
   logic [7:0]        cnt;
   logic              rw;
   logic              err;
   logic              acv;
   logic              ready;
   logic              valid;
   logic              mioen;
   logic              ready_n;
   logic              valid_n;
   logic              mioen_n;
   logic              accept;
   logic              timeout;
   logic              acv_hit;

   assign accept  = bus.req_valid && ready;
   assign timeout = (cnt == CNT_LAST);

`ifdef MEM_ACV_EN
   lc3_acv_check #(
      .ADDR_W (ADDR_W)
   ) u_acv (
      .addr (bus.req_addr),
      .priv (bus.priv),
      .viol (acv_hit)
   );
`else
   assign acv_hit = 1'b0;
`endif

   // Status outputs are flopped from the next state so none are decoded
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ready <= 1'b1;
         valid <= 1'b0;
         mioen <= 1'b0;
      end else begin
         state <= nxt;
         ready <= ready_n;
         valid <= valid_n;
         mioen <= mioen_n;
      end
   end

   always_comb begin
      nxt = state;
      unique case (1'b1)
         (state == IDLE):
            if (accept)
               nxt = acv_hit ? DONE : ACCESS;
         (state == ACCESS):
            if (bus.R || timeout)
               nxt = DONE;
         (state == DONE):
            nxt = IDLE;
         default:
            nxt = IDLE;
      endcase
   end

   always_comb begin
      ready_n = (nxt == IDLE);
      valid_n = (nxt == DONE);
      mioen_n = (nxt == ACCESS);
   end

   // R takes priority over an expiring timeout on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         mar <= '0;
         mdr <= '0;
         rw  <= 1'b0;
         err <= 1'b0;
         acv <= 1'b0;
         cnt <= '0;
      end else begin
         unique case (1'b1)
            (state == IDLE): begin
               if (accept) begin
                  mar <= bus.req_addr;
                  rw  <= bus.req_we;
                  cnt <= '0;
                  err <= 1'b0;
                  acv <= 1'b0;
                  if (bus.req_we)
                     mdr <= bus.req_wdata;
                  if (acv_hit) begin
                     mdr <= '0;
                     err <= 1'b1;
                     acv <= 1'b1;
                  end
               end
            end
            (state == ACCESS): begin
               if (bus.R) begin
                  if (!rw)
                     mdr <= bus.outData;
               end else if (timeout) begin
                  mdr <= '0;
                  err <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = valid;
   assign bus.rsp_rdata = mdr;
   assign bus.rsp_err   = err;
   assign bus.rsp_acv   = acv;
   assign bus.addr      = mar;
   assign bus.inData    = mdr;
   assign bus.RW        = rw;
   assign bus.MIOEN     = mioen;
endmodule
